// File: rtl/lrn_square_sum.sv
// Cross-channel sliding-window sum of squares for LRN, one output beat per channel.
// Latency: 4 cycles from accept/flush step to out_valid; steps spaced OUT_SPACING cycles apart.
module lrn_square_sum #(
    parameter int OP_WIDTH    = 16,
    parameter int NUM_PE      = 4,
    parameter int FRAC_BITS   = 8,
    parameter int LRN_SIZE    = 5,
    parameter int OUT_SPACING = NUM_PE + 1,
    parameter int CH_WIDTH    = 12
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    input  logic [CH_WIDTH-1:0]          num_channels,
    input  logic                         enable,
    output logic                         in_ready,
    input  logic [OP_WIDTH*NUM_PE-1:0]   data_in,
    output logic [OP_WIDTH*NUM_PE-1:0]   square_sum,
    output logic [OP_WIDTH*NUM_PE-1:0]   lrn_center,
    output logic                         out_valid,
    output logic                         busy,
    output logic                         done
);
    localparam int HALF = (LRN_SIZE - 1) / 2;
    localparam int VW   = OP_WIDTH * NUM_PE;
    localparam int CW   = CH_WIDTH + 1;
    localparam int SPW  = $clog2(OUT_SPACING + 1);
    localparam int SW   = OP_WIDTH + $clog2(LRN_SIZE + 1);
    localparam logic [CW-1:0]               HALF_C   = CW'(HALF);
    localparam logic [SPW-1:0]              SPC_LOAD = SPW'(OUT_SPACING - 1);
    localparam logic [OP_WIDTH-1:0]         POS_MAX  = {1'b0, {(OP_WIDTH-1){1'b1}}};
    localparam logic signed [2*OP_WIDTH-1:0] SQ_MAX  = {{(OP_WIDTH+1){1'b0}}, {(OP_WIDTH-1){1'b1}}};

    typedef enum logic [1:0] {IDLE, FILL, RUN, FLUSH} state_t;

    state_t                        state_q, state_d;
    logic [CH_WIDTH-1:0]           num_q, num_d;
    logic [CW-1:0]                 acc_q, acc_d, emit_q, emit_d;
    logic [SPW-1:0]                spc_q, spc_d;
    logic                          s0_vld_q, s0_vld_d, s0_emit_q, s0_emit_d;
    logic [VW-1:0]                 s0_dat_q, s0_dat_d;
    logic                          s1_vld_q, s1_vld_d, s1_emit_q, s1_emit_d;
    logic [VW-1:0]                 s1_sq_q, s1_sq_d, s1_raw_q, s1_raw_d;
    logic [LRN_SIZE-1:0][VW-1:0]   win_sq_q, win_sq_d, win_raw_q, win_raw_d;
    logic                          s2_vld_q, s2_vld_d, s2_emit_q, s2_emit_d;
    logic [VW-1:0]                 sum_q, sum_d, ctr_q, ctr_d;
    logic                          out_valid_q, out_valid_d, done_q, done_d;
    logic [CW-1:0]                 num_ext;
    logic                          accept, flush_step, clear_win;
    logic [SW-1:0]                 lane_sum;

    function automatic logic [OP_WIDTH-1:0] square_q(input logic [OP_WIDTH-1:0] x);
        logic signed [2*OP_WIDTH-1:0] xe;
        logic signed [2*OP_WIDTH-1:0] p;
        xe = {{OP_WIDTH{x[OP_WIDTH-1]}}, x};
        p  = (xe * xe) >>> FRAC_BITS;
        if (p > SQ_MAX) return POS_MAX;
        return p[OP_WIDTH-1:0];
    endfunction

    assign num_ext    = {1'b0, num_q};
    assign in_ready   = ((state_q == FILL) || (state_q == RUN)) && (spc_q == '0) && (acc_q < num_ext);
    assign accept     = enable && in_ready;
    // Flush keeps stepping until the last real channel has reached the window centre.
    assign flush_step = (state_q == FLUSH) && (spc_q == '0) && (acc_q < num_ext + HALF_C);

    always_comb begin
        state_d     = state_q;
        num_d       = num_q;
        acc_d       = acc_q;
        emit_d      = emit_q;
        spc_d       = (spc_q != '0) ? spc_q - SPW'(1) : spc_q;
        clear_win   = 1'b0;
        out_valid_d = 1'b0;
        done_d      = 1'b0;
        s0_vld_d    = 1'b0;
        s0_emit_d   = 1'b0;
        s0_dat_d    = s0_dat_q;
        if (accept || flush_step) begin
            spc_d     = SPC_LOAD;
            acc_d     = acc_q + CW'(1);
            s0_vld_d  = 1'b1;
            s0_emit_d = (acc_q >= HALF_C);
            s0_dat_d  = accept ? data_in : '0;
        end
        case (state_q)
            IDLE: begin
                // The done cycle already shows IDLE, so gate start on done_q.
                if (start && !done_q) begin
                    state_d   = FILL;
                    num_d     = num_channels;
                    acc_d     = '0;
                    emit_d    = '0;
                    spc_d     = '0;
                    clear_win = 1'b1;
                end
            end
            FILL: begin
                if (acc_d >= num_ext)     state_d = FLUSH;
                else if (acc_d >= HALF_C) state_d = RUN;
            end
            RUN: begin
                if (acc_d >= num_ext) state_d = FLUSH;
            end
            default: ;
        endcase
        if (s2_vld_q && s2_emit_q) begin
            out_valid_d = 1'b1;
            emit_d      = emit_q + CW'(1);
            if (emit_q + CW'(1) == num_ext) begin
                done_d  = 1'b1;
                state_d = IDLE;
            end
        end
    end

    always_comb begin
        s1_vld_d  = s0_vld_q;
        s1_emit_d = s0_emit_q;
        s1_raw_d  = s0_dat_q;
        for (int l = 0; l < NUM_PE; l++) begin
            s1_sq_d[l*OP_WIDTH +: OP_WIDTH] = square_q(s0_dat_q[l*OP_WIDTH +: OP_WIDTH]);
        end
        win_sq_d  = win_sq_q;
        win_raw_d = win_raw_q;
        if (clear_win) begin
            win_sq_d  = '0;
            win_raw_d = '0;
        end else if (s1_vld_q) begin
            win_sq_d[0]  = s1_sq_q;
            win_raw_d[0] = s1_raw_q;
            for (int k = 1; k < LRN_SIZE; k++) begin
                win_sq_d[k]  = win_sq_q[k-1];
                win_raw_d[k] = win_raw_q[k-1];
            end
        end
        s2_vld_d  = s1_vld_q;
        s2_emit_d = s1_emit_q;
        sum_d     = sum_q;
        ctr_d     = ctr_q;
        lane_sum  = '0;
        if (s2_vld_q && s2_emit_q) begin
            ctr_d = win_raw_q[HALF];
            for (int l = 0; l < NUM_PE; l++) begin
                lane_sum = '0;
                for (int k = 0; k < LRN_SIZE; k++) begin
                    lane_sum = lane_sum + SW'(win_sq_q[k][l*OP_WIDTH +: OP_WIDTH]);
                end
                sum_d[l*OP_WIDTH +: OP_WIDTH] = (lane_sum > SW'(POS_MAX)) ? POS_MAX : lane_sum[OP_WIDTH-1:0];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            num_q       <= '0;
            acc_q       <= '0;
            emit_q      <= '0;
            spc_q       <= '0;
            s0_vld_q    <= 1'b0;
            s0_emit_q   <= 1'b0;
            s0_dat_q    <= '0;
            s1_vld_q    <= 1'b0;
            s1_emit_q   <= 1'b0;
            s1_sq_q     <= '0;
            s1_raw_q    <= '0;
            win_sq_q    <= '0;
            win_raw_q   <= '0;
            s2_vld_q    <= 1'b0;
            s2_emit_q   <= 1'b0;
            sum_q       <= '0;
            ctr_q       <= '0;
            out_valid_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            num_q       <= num_d;
            acc_q       <= acc_d;
            emit_q      <= emit_d;
            spc_q       <= spc_d;
            s0_vld_q    <= s0_vld_d;
            s0_emit_q   <= s0_emit_d;
            s0_dat_q    <= s0_dat_d;
            s1_vld_q    <= s1_vld_d;
            s1_emit_q   <= s1_emit_d;
            s1_sq_q     <= s1_sq_d;
            s1_raw_q    <= s1_raw_d;
            win_sq_q    <= win_sq_d;
            win_raw_q   <= win_raw_d;
            s2_vld_q    <= s2_vld_d;
            s2_emit_q   <= s2_emit_d;
            sum_q       <= sum_d;
            ctr_q       <= ctr_d;
            out_valid_q <= out_valid_d;
            done_q      <= done_d;
        end
    end

    assign square_sum = sum_q;
    assign lrn_center = ctr_q;
    assign out_valid  = out_valid_q;
    assign done       = done_q;
    assign busy       = (state_q != IDLE);
endmodule

// File: tb/tb_lrn_square_sum.sv
// Randomized scoreboard bench for lrn_square_sum against a per-channel window reference model.
module tb_lrn_square_sum;
    localparam int W    = 16;
    localparam int NPE  = 4;
    localparam int HALF = 2;
    localparam int SPC  = NPE + 1;
    localparam int VW   = W * NPE;

    logic          clk = 1'b0;
    logic          rst_n, start, enable;
    logic [11:0]   num_channels;
    logic [VW-1:0] data_in, square_sum, lrn_center;
    logic          in_ready, out_valid, busy, done;

    lrn_square_sum dut (
        .clk(clk), .reset(rst_n), .start(start), .num_channels(num_channels),
        .enable(enable), .in_ready(in_ready), .data_in(data_in),
        .square_sum(square_sum), .lrn_center(lrn_center), .out_valid(out_valid),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [VW-1:0] sum;
        logic [VW-1:0] ctr;
        logic          last;
    } exp_t;

    exp_t          exp_q[$];
    logic [VW-1:0] vec [0:63];
    int            errors = 0;
    int            checks = 0;
    int            cyc = 0;
    int            last_acc = -1;
    int            last_out = -1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h want %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Reference: square with truncating fixed-point scale and clamp, summed over the
    // channel neighbourhood with out-of-range channels treated as absent.
    function automatic int sq_ref(input logic [15:0] x);
        int v;
        int p;
        v = int'($signed(x));
        p = (v * v) / 256;
        return (p > 32767) ? 32767 : p;
    endfunction

    task automatic push_expected(input int n);
        exp_t e;
        int   s;
        for (int c = 0; c < n; c++) begin
            e = '0;
            for (int l = 0; l < NPE; l++) begin
                s = 0;
                for (int j = c - HALF; j <= c + HALF; j++)
                    if (j >= 0 && j < n) s += sq_ref(vec[j][l*W +: W]);
                if (s > 32767) s = 32767;
                e.sum[l*W +: W] = 16'(s);
            end
            e.ctr  = vec[c];
            e.last = (c == n - 1);
            exp_q.push_back(e);
        end
    endtask

    task automatic rand_vecs(input int n);
        logic [15:0] v;
        for (int c = 0; c < n; c++)
            for (int l = 0; l < NPE; l++) begin
                case ($urandom_range(0, 2))
                    0:       v = 16'($urandom);
                    1:       v = 16'($urandom_range(0, 2047)) - 16'd1024;
                    default: v = $urandom_range(0, 1) ? 16'h7FFF : 16'h8000;
                endcase
                vec[c][l*W +: W] = v;
            end
    endtask

    task automatic reset_checks(input string tag);
        check({tag, "_out_valid"}, 64'(out_valid), 64'd0);
        check({tag, "_done"}, 64'(done), 64'd0);
        check({tag, "_busy"}, 64'(busy), 64'd0);
        check({tag, "_in_ready"}, 64'(in_ready), 64'd0);
        check({tag, "_square_sum"}, square_sum, 64'd0);
        check({tag, "_lrn_center"}, lrn_center, 64'd0);
    endtask

    // Monitor: scoreboard pop plus pacing checks, sampled mid-cycle.
    always @(negedge clk) begin
        exp_t e;
        cyc++;
        if (!rst_n) begin
            last_acc = -1;
            last_out = -1;
        end else begin
            if (enable && in_ready) begin
                if (last_acc >= 0) check("accept_spacing_ok", 64'(cyc - last_acc >= SPC), 64'd1);
                last_acc = cyc;
            end
            if (done) check("done_with_out_valid", 64'(out_valid), 64'd1);
            if (out_valid) begin
                if (last_out >= 0) check("out_spacing_ok", 64'(cyc - last_out >= SPC), 64'd1);
                last_out = cyc;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_out: got sum %h with nothing outstanding (cycle %0d)", square_sum, cyc);
                end else begin
                    e = exp_q.pop_front();
                    check("square_sum", square_sum, e.sum);
                    check("lrn_center", lrn_center, e.ctr);
                    check("done_on_last", 64'(done), 64'(e.last));
                    if (done) check("busy_low_at_done", 64'(busy), 64'd0);
                end
            end
        end
    end

    task automatic run_case(input int n, input int abort_after, input bit start_mid, input bit start_at_done);
        int idx;
        int guard;
        bit took;
        push_expected(n);
        @(posedge clk); #1;
        num_channels = 12'(n);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        idx = 0;
        guard = 0;
        while (idx < n && guard < 2000) begin
            data_in = vec[idx];
            enable  = ($urandom_range(0, 4) != 0);
            if (start_mid && idx == 1) begin
                start = 1'b1;
                num_channels = 12'd3;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            took = enable && in_ready;
            @(posedge clk); #1;
            guard++;
            if (took) idx++;
            if (abort_after > 0 && idx == abort_after) begin
                rst_n = 1'b0;
                enable = 1'b0;
                start = 1'b0;
                exp_q.delete();
                repeat (3) @(negedge clk);
                reset_checks("abort");
                @(posedge clk); #1;
                rst_n = 1'b1;
                repeat (12) @(posedge clk);
                #1;
                return;
            end
        end
        enable = 1'b0;
        start  = 1'b0;
        check("accepts", 64'(idx), 64'(n));
        guard = 0;
        @(negedge clk);
        while (!done && guard < 500) begin
            @(negedge clk);
            guard++;
        end
        check("done_seen", 64'(done), 64'd1);
        if (start_at_done) start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("idle_after_run", 64'(busy), 64'd0);
        check("outputs_outstanding", 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        enable = 1'b0;
        num_channels = '0;
        data_in = '0;
        repeat (3) @(negedge clk);
        reset_checks("reset");
        @(posedge clk); #1;
        rst_n = 1'b1;

        for (int c = 0; c < 8; c++) vec[c] = {4{16'h0100}};
        run_case(8, 0, 1'b0, 1'b0);

        vec[0] = {16'h7FFF, 16'hFE00, 16'h8000, 16'h0001};
        vec[1] = {16'h7FFF, 16'hFE00, 16'h0100, 16'hFFFF};
        vec[2] = {16'h7FFF, 16'h0000, 16'h8000, 16'h0180};
        vec[3] = {16'h0000, 16'hFE00, 16'h7FFF, 16'hFF00};
        run_case(4, 0, 1'b0, 1'b0);

        vec[0] = {4{16'h0200}};
        run_case(1, 0, 1'b0, 1'b1);

        for (int r = 0; r < 6; r++) begin
            int n;
            n = $urandom_range(1, 12);
            rand_vecs(n);
            run_case(n, 0, (r == 1), (r == 2));
        end

        rand_vecs(8);
        run_case(8, 3, 1'b0, 1'b0);
        rand_vecs(4);
        run_case(4, 0, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
